// File: rtl/pipe_pkg.sv
// Shared constants for the four-stage pipeline hazard controller.
package pipe_pkg;
  localparam int NREG = 4;
  localparam int REGW = 2;

  localparam int S_FETCH = 0;
  localparam int S_READ  = 1;
  localparam int S_EXEC  = 2;
  localparam int S_WB    = 3;

  localparam logic [1:0] CNT_MAX = 2'd2;

  typedef logic [REGW-1:0] reg_idx_t;
endpackage

// File: rtl/sb_counter.sv
// Pending-write counter for one register: 2-bit up/down, saturating, with an error pulse.
module sb_counter
  import pipe_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic busy,
  output logic err
);
  logic [1:0] cnt;
  logic       ovf;
  logic       unf;

  // Simultaneous inc and dec cancel, so neither can over/underflow.
  assign ovf  = inc & ~dec & (cnt == CNT_MAX);
  assign unf  = dec & ~inc & (cnt == 2'd0);
  assign err  = ovf | unf;
  assign busy = (cnt != 2'd0);

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= 2'd0;
    end else if (inc & ~dec & ~ovf) begin
      cnt <= cnt + 2'd1;
    end else if (dec & ~inc & ~unf) begin
      cnt <= cnt - 2'd1;
    end
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stage sequencer for the 4-stage pipe: RAW stalls via a per-register scoreboard,
// branch flush of S1/S2, and a sticky freeze once a stop instruction retires.
module pipe_hazard_ctrl
  import pipe_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            use2_a,
  input  logic [REGW-1:0] rd2_a,
  input  logic            use2_b,
  input  logic [REGW-1:0] rd2_b,
  input  logic            wr2,
  input  logic [REGW-1:0] wr2_reg,
  input  logic            branch,
  input  logic            stop4,
  output logic            ir1_load,
  output logic            ir2_load,
  output logic            ir3_load,
  output logic            ir4_load,
  output logic            en_fetch,
  output logic            en_read,
  output logic            en_exec,
  output logic            en_wb,
  output logic            stall,
  output logic            flush,
  output logic            halted,
  output logic [NREG-1:0] busy,
  output logic            sb_err
);
  logic [S_WB:S_FETCH] v;
  logic                wr3;
  logic                wr4;
  reg_idx_t            reg3;
  reg_idx_t            reg4;
  logic                halted_q;
  logic                sb_err_q;
  logic                hazard;
  logic                issue;
  logic [NREG-1:0]     inc;
  logic [NREG-1:0]     dec;
  logic [NREG-1:0]     cnt_err;

  always_comb begin
    flush  = v[S_EXEC] & branch & ~halted_q;
    hazard = (use2_a & busy[rd2_a]) | (use2_b & busy[rd2_b]);
    stall  = v[S_READ] & hazard & ~flush & ~halted_q;
    issue  = v[S_READ] & ~stall & ~flush & ~halted_q;
  end

  // A stall freezes S1/S2; S3 still loads (a bubble) and S4 always advances.
  always_comb begin
    ir1_load = ~halted_q & ~stall;
    ir2_load = ~halted_q & ~stall;
    ir3_load = ~halted_q;
    ir4_load = ~halted_q;
    en_fetch = ~halted_q & ~stall;
    en_read  = v[S_READ] & ~halted_q;
    en_exec  = v[S_EXEC] & ~halted_q;
    en_wb    = v[S_WB] & ~halted_q;
  end

  always_comb begin
    inc = '0;
    dec = '0;
    for (int r = 0; r < NREG; r++) begin
      inc[r] = issue & wr2 & (wr2_reg == reg_idx_t'(r));
      dec[r] = en_wb & wr4 & (reg4 == reg_idx_t'(r));
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_sb
    sb_counter u_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (inc[g]),
      .dec   (dec[g]),
      .busy  (busy[g]),
      .err   (cnt_err[g])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      v        <= '0;
      wr3      <= 1'b0;
      wr4      <= 1'b0;
      reg3     <= '0;
      reg4     <= '0;
      halted_q <= 1'b0;
      sb_err_q <= 1'b0;
    end else begin
      sb_err_q <= sb_err_q | (|cnt_err);
      if (!halted_q) begin
        halted_q  <= en_wb & stop4;
        v[S_WB]   <= v[S_EXEC];
        wr4       <= wr3;
        reg4      <= reg3;
        v[S_EXEC] <= issue;
        wr3       <= issue & wr2;
        reg3      <= wr2_reg;
        if (flush) begin
          v[S_FETCH] <= 1'b0;
          v[S_READ]  <= 1'b0;
        end else if (!stall) begin
          v[S_READ]  <= v[S_FETCH];
          v[S_FETCH] <= 1'b1;
        end
      end
    end
  end

  assign halted = halted_q;
  assign sb_err = sb_err_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vector table, halt and scoreboard-error
// sequences, then random traffic against an in-flight-instruction model.
module tb_pipe_hazard_ctrl;
  logic       clock;
  logic       reset;
  logic       use2_a, use2_b, wr2, branch, stop4;
  logic [1:0] rd2_a, rd2_b, wr2_reg;
  logic       ir1_load, ir2_load, ir3_load, ir4_load;
  logic       en_fetch, en_read, en_exec, en_wb;
  logic       stall, flush, halted, sb_err;
  logic [3:0] busy;

  pipe_hazard_ctrl dut (
    .clock(clock), .reset(reset),
    .use2_a(use2_a), .rd2_a(rd2_a), .use2_b(use2_b), .rd2_b(rd2_b),
    .wr2(wr2), .wr2_reg(wr2_reg), .branch(branch), .stop4(stop4),
    .ir1_load(ir1_load), .ir2_load(ir2_load), .ir3_load(ir3_load), .ir4_load(ir4_load),
    .en_fetch(en_fetch), .en_read(en_read), .en_exec(en_exec), .en_wb(en_wb),
    .stall(stall), .flush(flush), .halted(halted), .busy(busy), .sb_err(sb_err)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic       use_a;
    logic [1:0] ra;
    logic       use_b;
    logic [1:0] rb;
    logic       wr;
    logic [1:0] wreg;
    logic       branch;
    logic       stop;
  } in_t;

  // loads = {ir1,ir2,ir3,ir4}, ens = {fetch,read,exec,wb}
  typedef struct packed {
    logic [3:0] loads;
    logic [3:0] ens;
    logic       stall;
    logic       flush;
    logic       halted;
    logic [3:0] busy;
    logic       sb_err;
  } outs_t;

  typedef struct packed {
    logic  seg;
    in_t   in;
    outs_t exp;
  } vec_t;

  typedef struct packed {
    logic       valid;
    logic       wr;
    logic [1:0] dst;
  } stg_t;

  outs_t act;
  assign act = {ir1_load, ir2_load, ir3_load, ir4_load,
                en_fetch, en_read, en_exec, en_wb,
                stall, flush, halted, busy, sb_err};

  int total = 0;
  int bad   = 0;

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input in_t x, input logic rst);
    reset   = rst;
    use2_a  = x.use_a;
    rd2_a   = x.ra;
    use2_b  = x.use_b;
    rd2_b   = x.rb;
    wr2     = x.wr;
    wr2_reg = x.wreg;
    branch  = x.branch;
    stop4   = x.stop;
  endtask

  task automatic do_reset();
    drive(in_t'(0), 1'b1);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // ---------------- reference model ----------------
  // The pipe is a row of instruction slots; a register is busy while some
  // writer of it sits in S3 or S4.
  stg_t p1, p2, p3, p4;
  logic m_halted;

  function automatic void model_clear();
    p1 = '0; p2 = '0; p3 = '0; p4 = '0;
    m_halted = 1'b0;
  endfunction

  function automatic int pending(input logic [1:0] r);
    int n = 0;
    if (p3.valid && p3.wr && p3.dst == r) n++;
    if (p4.valid && p4.wr && p4.dst == r) n++;
    return n;
  endfunction

  function automatic outs_t model_out(input in_t x);
    outs_t o;
    logic fl, st, hz;
    fl = p3.valid && x.branch && !m_halted;
    hz = (x.use_a && pending(x.ra) > 0) || (x.use_b && pending(x.rb) > 0);
    st = p2.valid && hz && !fl && !m_halted;
    o.loads  = m_halted ? 4'b0000 : (st ? 4'b0011 : 4'b1111);
    o.ens    = m_halted ? 4'b0000 : {~st, p2.valid, p3.valid, p4.valid};
    o.stall  = st;
    o.flush  = fl;
    o.halted = m_halted;
    for (int r = 0; r < 4; r++) o.busy[r] = (pending(2'(r)) > 0);
    o.sb_err = 1'b0;
    return o;
  endfunction

  function automatic void model_step(input in_t x, input logic rst);
    outs_t o;
    logic  nh;
    if (rst) begin
      model_clear();
    end else if (!m_halted) begin
      o  = model_out(x);
      nh = p4.valid && x.stop;
      p4 = p3;
      if (p2.valid && !o.stall && !o.flush) p3 = '{valid: 1'b1, wr: x.wr, dst: x.wreg};
      else p3 = '0;
      if (o.flush) begin
        p1 = '0;
        p2 = '0;
      end else if (!o.stall) begin
        p2 = p1;
        p1 = '{valid: 1'b1, wr: 1'b0, dst: 2'd0};
      end
      m_halted = nh;
    end
  endfunction

  task automatic mcycle(input in_t x, input logic rst, input string tag);
    outs_t e;
    drive(x, rst);
    #1;
    e = model_out(x);
    chk(tag, 32'(act), 32'(e));
    model_step(x, rst);
    @(negedge clock);
  endtask

  function automatic in_t rand_in();
    in_t x;
    x.use_a  = ($urandom_range(0, 1) == 1);
    x.ra     = 2'($urandom_range(0, 3));
    x.use_b  = ($urandom_range(0, 1) == 1);
    x.rb     = 2'($urandom_range(0, 3));
    x.wr     = ($urandom_range(0, 1) == 1);
    x.wreg   = 2'($urandom_range(0, 3));
    x.branch = ($urandom_range(0, 5) == 0);
    x.stop   = ($urandom_range(0, 149) == 0);
    return x;
  endfunction

  // ---------------- vector helpers ----------------
  function automatic outs_t mk_out(input logic [3:0] ld, input logic [3:0] en,
                                   input logic st, input logic fl, input logic [3:0] bz);
    return '{loads: ld, ens: en, stall: st, flush: fl, halted: 1'b0, busy: bz, sb_err: 1'b0};
  endfunction

  function automatic in_t wr_in(input logic [1:0] r);
    return '{use_a: 1'b0, ra: 2'd0, use_b: 1'b0, rb: 2'd0, wr: 1'b1, wreg: r, branch: 1'b0, stop: 1'b0};
  endfunction

  function automatic in_t rd_in(input logic [1:0] r);
    return '{use_a: 1'b1, ra: r, use_b: 1'b0, rb: 2'd0, wr: 1'b0, wreg: 2'd0, branch: 1'b0, stop: 1'b0};
  endfunction

  vec_t tbl[$];

  initial begin
    in_t nop, x;
    nop = '0;

    // RAW hazard: I0 writes r1, I1 reads r1 -> two stall cycles.
    tbl.push_back('{1'b1, nop,       mk_out(4'hf, 4'b1000, 0, 0, 4'b0000)});
    tbl.push_back('{1'b0, nop,       mk_out(4'hf, 4'b1000, 0, 0, 4'b0000)});
    tbl.push_back('{1'b0, wr_in(1),  mk_out(4'hf, 4'b1100, 0, 0, 4'b0000)});
    tbl.push_back('{1'b0, rd_in(1),  mk_out(4'b0011, 4'b0110, 1, 0, 4'b0010)});
    tbl.push_back('{1'b0, rd_in(1),  mk_out(4'b0011, 4'b0101, 1, 0, 4'b0010)});
    tbl.push_back('{1'b0, rd_in(1),  mk_out(4'hf, 4'b1100, 0, 0, 4'b0000)});
    tbl.push_back('{1'b0, nop,       mk_out(4'hf, 4'b1110, 0, 0, 4'b0000)});
    tbl.push_back('{1'b0, nop,       mk_out(4'hf, 4'b1111, 0, 0, 4'b0000)});
    // Branch in S3 while S2 would stall on r2; killed S2 writer of r3 never counts.
    x = '{use_a: 1'b1, ra: 2'd2, use_b: 1'b0, rb: 2'd0, wr: 1'b1, wreg: 2'd3, branch: 1'b1, stop: 1'b0};
    tbl.push_back('{1'b1, nop,       mk_out(4'hf, 4'b1000, 0, 0, 4'b0000)});
    tbl.push_back('{1'b0, nop,       mk_out(4'hf, 4'b1000, 0, 0, 4'b0000)});
    tbl.push_back('{1'b0, wr_in(2),  mk_out(4'hf, 4'b1100, 0, 0, 4'b0000)});
    tbl.push_back('{1'b0, nop,       mk_out(4'hf, 4'b1110, 0, 0, 4'b0100)});
    tbl.push_back('{1'b0, x,         mk_out(4'hf, 4'b1111, 0, 1, 4'b0100)});
    tbl.push_back('{1'b0, nop,       mk_out(4'hf, 4'b1001, 0, 0, 4'b0000)});
    tbl.push_back('{1'b0, nop,       mk_out(4'hf, 4'b1000, 0, 0, 4'b0000)});
    tbl.push_back('{1'b0, nop,       mk_out(4'hf, 4'b1100, 0, 0, 4'b0000)});
    // Same-edge retire and issue of r3 writers: count holds at 1.
    tbl.push_back('{1'b1, nop,       mk_out(4'hf, 4'b1000, 0, 0, 4'b0000)});
    tbl.push_back('{1'b0, nop,       mk_out(4'hf, 4'b1000, 0, 0, 4'b0000)});
    tbl.push_back('{1'b0, wr_in(3),  mk_out(4'hf, 4'b1100, 0, 0, 4'b0000)});
    tbl.push_back('{1'b0, nop,       mk_out(4'hf, 4'b1110, 0, 0, 4'b1000)});
    tbl.push_back('{1'b0, wr_in(3),  mk_out(4'hf, 4'b1111, 0, 0, 4'b1000)});
    tbl.push_back('{1'b0, nop,       mk_out(4'hf, 4'b1111, 0, 0, 4'b1000)});
    tbl.push_back('{1'b0, nop,       mk_out(4'hf, 4'b1111, 0, 0, 4'b1000)});
    tbl.push_back('{1'b0, nop,       mk_out(4'hf, 4'b1111, 0, 0, 4'b0000)});

    drive(nop, 1'b1);
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].seg) do_reset();
      drive(tbl[i].in, 1'b0);
      #1;
      chk($sformatf("vec%0d", i), 32'(act), 32'(tbl[i].exp));
      @(negedge clock);
    end

    // Halt: stop retires at cycle 4, then everything freezes until reset.
    do_reset();
    model_clear();
    for (int i = 0; i < 4; i++) mcycle(nop, 1'b0, "halt_fill");
    x = nop;
    x.stop = 1'b1;
    drive(x, 1'b0);
    #1;
    chk("halt_stop_en_wb", 32'(en_wb), 32'd1);
    mcycle(x, 1'b0, "halt_stop_cycle");
    #1;
    chk("halt_set", 32'(halted), 32'd1);
    for (int i = 0; i < 10; i++) begin
      x = rand_in();
      mcycle(x, 1'b0, "halt_frozen");
      chk($sformatf("halt_loads%0d", i),
          32'({ir1_load, ir2_load, ir3_load, ir4_load, en_fetch, en_read, en_exec, en_wb}), 32'd0);
    end
    mcycle(nop, 1'b1, "halt_reset_cycle");
    drive(nop, 1'b0);
    #1;
    chk("post_reset", 32'(act), 32'(mk_out(4'hf, 4'b1000, 0, 0, 4'b0000)));
    @(negedge clock);

    // Scoreboard underflow: force a retiring non-writer to look like a writer.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(nop, 1'b0);
      @(negedge clock);
    end
    force dut.wr4 = 1'b1;
    #1;
    chk("err_before", 32'(sb_err), 32'd0);
    @(posedge clock);
    #1;
    release dut.wr4;
    @(negedge clock);
    chk("err_set", 32'(sb_err), 32'd1);
    chk("err_busy_sat", 32'(busy), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk($sformatf("err_sticky%0d", i), 32'(sb_err), 32'd1);
    end
    do_reset();
    chk("err_cleared", 32'(sb_err), 32'd0);

    // Random traffic with occasional stop and reset.
    do_reset();
    model_clear();
    for (int i = 0; i < 3000; i++) begin
      x = rand_in();
      mcycle(x, ($urandom_range(0, 249) == 0), $sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
